aes_round_ctrl: RTL

- Sequencer for the cipher unit's 11-entry round-key store and the round datapath.
- Drives the write side of the round-key store: the 4-bit select and 1-bit data/enable feeding the 1-to-11 demux.
- Drives the read select for the round-key mux and the per-round stage enables (SubBytes, ShiftRows, MixColumns, AddRoundKey).
- Handshakes with the key-expansion unit and the top-level start/done interface.

---
 rtl/aes_round_ctrl_pkg.sv | 23 ++
 rtl/aes_round_ctrl_if.sv | 41 ++++
 rtl/aes_round_ctrl_round_cnt.sv | 42 ++++
 rtl/aes_round_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/aes_round_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_ctrl_pkg : shared state encoding and defaults for aes_round_ctrl |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    LOAD  = 3'd2,
    ARK0  = 3'd3,
    RND   = 3'd4,
    FINAL = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int NR_DEF = 10;
  localparam int NK_DEF = 11;
  localparam int CW_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_round_ctrl_if : start/key handshakes and round-control outputs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface aes_round_ctrl_if #(
  parameter int CW = 4
);

  logic          key_start;
  logic          kexp_valid;
  logic          start;
  logic          rk_we;
  logic [CW-1:0] rk_wsel;
  logic [CW-1:0] rk_rsel;
  logic          load_pt;
  logic          sb_en;
  logic          sr_en;
  logic          mc_en;
  logic          ark_en;
  logic [CW-1:0] round;
  logic          keys_valid;
  logic          busy;
  logic          key_done;
  logic          done;
  logic          start_err;

  modport master (
    output key_start, kexp_valid, start,
    input  rk_we, rk_wsel, rk_rsel, load_pt, sb_en, sr_en, mc_en, ark_en,
           round, keys_valid, busy, key_done, done, start_err
  );

  modport slave (
    input  key_start, kexp_valid, start,
    output rk_we, rk_wsel, rk_rsel, load_pt, sb_en, sr_en, mc_en, ark_en,
           round, keys_valid, busy, key_done, done, start_err
  );

endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl_round_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | round_cnt : CW-bit counter, sync clear over enable, tc at limit    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module round_cnt #(
  parameter int CW = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr_i,
  input  wire logic          en_i,
  input  wire logic [CW-1:0] limit_i,
  output logic      [CW-1:0] cnt_o,
  output logic               tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_round_ctrl : round-key store writer and round datapath sequencer|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = NR_DEF,
  parameter int CW = CW_DEF
) (
  input wire logic        clk,
  input wire logic        rst,
  aes_round_ctrl_if.slave ctrl
);

  localparam logic [CW-1:0] C_NR    = CW'(NR);
  localparam logic [CW-1:0] C_NR_M1 = CW'(NR - 1);

  state_t        state_q, state_d;
  logic          rk_we_q, rk_we_d;
  logic [CW-1:0] rk_wsel_q, rk_wsel_d;
  logic          keys_valid_q, keys_valid_d;
  logic          last_wr_q, last_wr_d;
  logic          key_done_q, key_done_d;
  logic          start_err_q, start_err_d;

  logic          kcnt_clr, kcnt_en, kcnt_tc;
  logic [CW-1:0] kcnt;
  logic          rnd_clr, rnd_en, rnd_tc;
  logic [CW-1:0] rnd_cnt;
  logic          in_rounds;

  round_cnt #(.CW(CW)) u_kcnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (kcnt_clr),
    .en_i    (kcnt_en),
    .limit_i (C_NR),
    .cnt_o   (kcnt),
    .tc_o    (kcnt_tc)
  );

  round_cnt #(.CW(CW)) u_rnd_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (rnd_clr),
    .en_i    (rnd_en),
    .limit_i (C_NR_M1),
    .cnt_o   (rnd_cnt),
    .tc_o    (rnd_tc)
  );

  always_comb begin
    state_d      = state_q;
    rk_we_d      = 1'b0;
    rk_wsel_d    = '0;
    keys_valid_d = keys_valid_q;
    last_wr_d    = 1'b0;
    key_done_d   = last_wr_q;
    start_err_d  = 1'b0;
    kcnt_clr     = 1'b0;
    kcnt_en      = 1'b0;
    rnd_clr      = 1'b0;
    rnd_en       = 1'b0;

    // keys_valid/key_done trail the final store write by one cycle
    if (last_wr_q) begin
      keys_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (ctrl.key_start) begin
          state_d      = KEXP;
          kcnt_clr     = 1'b1;
          keys_valid_d = 1'b0;
          key_done_d   = 1'b0;
        end else if (ctrl.start) begin
          if (keys_valid_q) begin
            state_d = LOAD;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      KEXP: begin
        if (ctrl.kexp_valid) begin
          rk_we_d   = 1'b1;
          rk_wsel_d = kcnt;
          kcnt_en   = 1'b1;
          if (kcnt_tc) begin
            state_d   = IDLE;
            last_wr_d = 1'b1;
            kcnt_clr  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d = ARK0;
      end
      ARK0: begin
        rnd_en  = 1'b1;
        state_d = (NR > 1) ? RND : FINAL;
      end
      RND: begin
        rnd_en = 1'b1;
        if (rnd_tc) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = DONE;
      end
      DONE: begin
        rnd_clr = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rk_we_q      <= 1'b0;
      rk_wsel_q    <= '0;
      keys_valid_q <= 1'b0;
      last_wr_q    <= 1'b0;
      key_done_q   <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rk_we_q      <= rk_we_d;
      rk_wsel_q    <= rk_wsel_d;
      keys_valid_q <= keys_valid_d;
      last_wr_q    <= last_wr_d;
      key_done_q   <= key_done_d;
      start_err_q  <= start_err_d;
    end
  end

  // The round counter already equals the key index in ARK0, RND and FINAL
  assign in_rounds = (state_q == ARK0) || (state_q == RND) || (state_q == FINAL);

  assign ctrl.rk_we      = rk_we_q;
  assign ctrl.rk_wsel    = rk_wsel_q;
  assign ctrl.rk_rsel    = in_rounds ? rnd_cnt : '0;
  assign ctrl.load_pt    = (state_q == LOAD);
  assign ctrl.sb_en      = (state_q == RND) || (state_q == FINAL);
  assign ctrl.sr_en      = (state_q == RND) || (state_q == FINAL);
  assign ctrl.mc_en      = (state_q == RND);
  assign ctrl.ark_en     = in_rounds;
  assign ctrl.round      = rnd_cnt;
  assign ctrl.keys_valid = keys_valid_q;
  assign ctrl.busy       = (state_q != IDLE);
  assign ctrl.key_done   = key_done_q;
  assign ctrl.done       = (state_q == DONE);
  assign ctrl.start_err  = start_err_q;

endmodule
`default_nettype wire
